// File: rtl/gamepad_pkg.sv
// gamepad_pkg: direction type, constants and button decode helpers
package gamepad_pkg;
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;
  typedef struct packed {
    logic valid;
    dir_t dir;
  } cmd_t;
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'd2;
  endfunction
  function automatic cmd_t btn_to_cmd(input logic u, input logic d, input logic l, input logic r);
    cmd_t c;
    c.valid = u | d | l | r;
    c.dir   = u ? DIR_UP : d ? DIR_DOWN : l ? DIR_LEFT : DIR_RIGHT;
    return c;
  endfunction
endpackage

// File: rtl/dir_cmd_fifo.sv
// dir_cmd_fifo: synchronous direction FIFO; a same-cycle pop frees a slot for the push
module dir_cmd_fifo
  import gamepad_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  dir_t                     din_i,
  input  logic                     pop_i,
  output dir_t                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  dir_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  assign full_o  = count_q == FULL_CNT;
  assign empty_o = count_q == '0;
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;
  // gate requests by occupancy and compute next pointers/count
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/gamepad_dir_scheduler.sv
// gamepad_dir_scheduler: D-pad edges from two controllers, arbitrated into a tick-drained direction queue
module gamepad_dir_scheduler
  import gamepad_pkg::*;
#(
  parameter int   FIFO_DEPTH = 2,
  parameter dir_t INIT_DIR   = 2'd1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    up,
  input  logic [1:0]                    down,
  input  logic [1:0]                    left,
  input  logic [1:0]                    right,
  input  logic [1:0]                    is_present,
  input  logic                          game_tick,
  output logic [1:0]                    dir,
  output logic                          dir_changed,
  output logic                          cmd_dropped,
  output logic [$clog2(FIFO_DEPTH):0]   queue_count
);
  logic [1:0] up_q, down_q, left_q, right_q;
  logic [1:0] pend_v_q, pend_v_d;
  dir_t       pend_dir_q [2];
  dir_t       pend_dir_d [2];
  logic       rr_q, rr_d;
  dir_t       tail_q, tail_d, dir_q, dir_d;
  logic       dir_changed_q, dir_changed_d, cmd_dropped_q, cmd_dropped_d;
  cmd_t       press [2];
  logic [1:0] req, gnt;
  logic       gnt_v, gnt_id, accept, pop, push_ok;
  dir_t       cmd, head;
  logic       full, empty;
  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;
  assign cmd_dropped = cmd_dropped_q;
  // edge detect, arbitration, filter and next-state for all control registers
  always_comb begin
    for (int i = 0; i < 2; i++)
      press[i] = btn_to_cmd(up[i] & ~up_q[i], down[i] & ~down_q[i],
                            left[i] & ~left_q[i], right[i] & ~right_q[i]);
    req     = pend_v_q & is_present;
    gnt_v   = |req;
    gnt_id  = &req ? rr_q : req[1];
    gnt     = {gnt_v & gnt_id, gnt_v & ~gnt_id};
    cmd     = pend_dir_q[gnt_id];
    accept  = gnt_v && cmd != tail_q && cmd != opposite(tail_q);
    pop     = game_tick & ~empty;
    push_ok = accept & (~full | pop);
    for (int i = 0; i < 2; i++) begin
      pend_v_d[i]   = is_present[i] & (press[i].valid | (pend_v_q[i] & ~gnt[i]));
      pend_dir_d[i] = press[i].valid ? press[i].dir : pend_dir_q[i];
    end
    rr_d          = &req ? ~rr_q : rr_q;
    tail_d        = push_ok ? cmd : tail_q;
    dir_d         = pop ? head : dir_q;
    dir_changed_d = pop & (head != dir_q);
    cmd_dropped_d = accept & full & ~pop;
  end
  // state registers; reset clears pending state and restores the initial heading
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_q          <= '0;
      down_q        <= '0;
      left_q        <= '0;
      right_q       <= '0;
      pend_v_q      <= '0;
      pend_dir_q[0] <= INIT_DIR;
      pend_dir_q[1] <= INIT_DIR;
      rr_q          <= 1'b0;
      tail_q        <= INIT_DIR;
      dir_q         <= INIT_DIR;
      dir_changed_q <= 1'b0;
      cmd_dropped_q <= 1'b0;
    end else begin
      up_q          <= up;
      down_q        <= down;
      left_q        <= left;
      right_q       <= right;
      pend_v_q      <= pend_v_d;
      pend_dir_q[0] <= pend_dir_d[0];
      pend_dir_q[1] <= pend_dir_d[1];
      rr_q          <= rr_d;
      tail_q        <= tail_d;
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      cmd_dropped_q <= cmd_dropped_d;
    end
  end
  dir_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .din_i   (cmd),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (queue_count)
  );
endmodule

// File: doc/gamepad_dir_scheduler.md
Name: gamepad_dir_scheduler

Overview:
Turns live button states from the dual gamepad decoder into an ordered stream of snake direction commands. It edge-detects the D-pad on both controllers and holds one pending press per controller. A round-robin arbiter shares a single command queue between the two controllers, and the queue is drained one entry per game tick. It sits between the gamepad decoder outputs and the snake movement engine.

Parameters:
FIFO_DEPTH, 2, number of queued direction commands; power of two, at least 2
INIT_DIR, 2'd1, direction after reset (0=up, 1=right, 2=down, 3=left)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
up  in  2  button level per controller; bit0 = controller 0, bit1 = controller 1
down  in  2  as above
left  in  2  as above
right  in  2  as above
is_present  in  2  controller-connected flags from the decoder
game_tick  in  1  one-cycle pulse; the snake advances one cell
dir  out  2  committed direction; drives the movement engine
dir_changed  out  1  one-cycle pulse when dir takes a new value
cmd_dropped  out  1  one-cycle pulse when an arbitrated command is rejected because the FIFO is full
queue_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is synchronous. On reset: dir=INIT_DIR, tail_dir=INIT_DIR, FIFO empty, queue_count=0, pending registers empty, previous-button registers=0, round-robin pointer=0, dir_changed=0, cmd_dropped=0.
- Direction encoding: 0=up, 1=right, 2=down, 3=left. The opposite of d is d^2.
- Edge detect, per controller: a press is a 0→1 transition of a button level, registered against the previous cycle's level. When several buttons rise in the same cycle, priority is up > down > left > right.
- Pending register, per controller: holds one valid direction.
  - A new press overwrites the pending value, including while it waits for a grant.
  - A press is ignored, and the pending register cleared, while is_present[i]=0.
- Arbiter: at most one grant per cycle among valid pending registers.
  - If only one controller is pending, it is granted.
  - If both are pending, the controller selected by the round-robin pointer is granted. The pointer then moves to the other controller; it changes only on a contended grant.
  - The granted pending register clears in the cycle after the grant. The loser stays pending.
- Filter, applied to the granted command c: if c==tail_dir or c==(tail_dir^2), c is discarded silently. The pending register still clears and cmd_dropped stays 0.
  - tail_dir is the last accepted direction, or dir when nothing has been accepted since reset.
- Push: an accepted c is written to the FIFO and tail_dir<=c, provided the FIFO is not full after any same-cycle pop.
  - If the FIFO is full and there is no pop in that cycle: drop c, pulse cmd_dropped for 1 cycle, leave tail_dir unchanged.
- Pop: on game_tick with the FIFO non-empty, dir<=head and the entry is removed. dir_changed pulses in the following cycle, aligned with the new dir value.
  - game_tick with an empty FIFO changes nothing.
- Push and pop in the same cycle: the pop frees a slot first, so a push into a full FIFO succeeds and queue_count is unchanged.
- Latency: button rise at cycle N → pending valid at N+1 → grant and push at N+1 (visible in queue_count at N+2) → applied at the next game_tick.
- Pointers wrap modulo FIFO_DEPTH. queue_count never exceeds FIFO_DEPTH and never underflows.
- A controller that disconnects while its command sits in the FIFO does not purge that command. Only pending state is cleared.
- Reset asserted mid-operation discards the queue and all pending state within the same clock edge.

Decomposition:
- Shared package gamepad_pkg holds:
  - the direction typedef and the constants DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3;
  - an opposite-direction function;
  - the button-to-direction priority function.
- One natural sub-module: dir_cmd_fifo, a synchronous FIFO of width 2 and depth FIFO_DEPTH with count output and simultaneous push/pop.
- Edge detect, pending registers, arbiter and filter stay in the top module.

Test Plan:
- Reset then idle, with 10 game_ticks → dir=1 for the whole run, dir_changed never pulses, queue_count=0.
- Controller 0 presses up, then game_tick → queue_count=1, and after the tick dir=0, dir_changed is a single pulse, queue_count=0.
- From dir=1, press left (reversal), then right (same direction) → both discarded, queue_count=0, cmd_dropped=0.
- Both controllers rise in the same cycle, c0=up and c1=down, from dir=1 → c0 granted first, so up is queued. c1 is granted next cycle, but down is the opposite of tail_dir=up and is discarded. The round-robin pointer is 1 afterwards.
- FIFO_DEPTH=2, starting from dir=1, presses up, left, down with no tick → first two queued, third dropped with one cmd_dropped pulse. Pressing down with a game_tick in the same cycle → queue_count stays 2 and the entry is accepted.
- is_present[1] falls while c1 is pending, or reset is asserted with queue_count=2 → pending cleared with no push; after reset, dir=1 and queue_count=0 on the next cycle.
